// File: rtl/two_channel_data_fetch.sv
// Two-channel ROM fetch engine: issues four reads per block to a pair of
// ROM channels, packs the four returned bytes of each channel into a 2x2
// matrix word, and hands both matrices downstream with a valid/ready
// handshake. NUM_BLOCKS blocks are fetched per start request.
module two_channel_data_fetch #(
   parameter int NUM_BLOCKS  = 2,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        I_sys_clk,
   input  logic        I_sys_rstn,
   input  logic        I_start,
   input  logic        I_matrix_ready,
   input  logic [7:0]  I_data_from_channelA,
   input  logic [7:0]  I_data_from_channelB,
   input  logic        I_two_channel_data_valid,
   output logic        O_rom_ena,
   output logic [2:0]  O_addr,
   output logic [31:0] O_matrix_A,
   output logic [31:0] O_matrix_B,
   output logic        O_matrix_valid,
   output logic        O_busy,
   output logic        O_done
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] DRAIN   = 3'd2;
   localparam logic [2:0] PRESENT = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [1:0] LAST_WORD  = 2'(BLOCK_WORDS - 1);
   localparam logic       LAST_BLOCK = 1'(NUM_BLOCKS - 1);

   logic [2:0]  state_reg, state_next;
   logic        block_reg, block_next;
   logic [1:0]  issue_cnt_reg, issue_cnt_next;
   logic [1:0]  word_cnt_reg, word_cnt_next;
   logic [2:0]  addr_reg, addr_next;
   logic [31:0] mat_a_reg, mat_b_reg;
   logic        capture;

   // ROM data only counts while a block is in flight; stray valids elsewhere
   // must never touch the packed matrices.
   assign capture = I_two_channel_data_valid && ((state_reg == ISSUE) || (state_reg == DRAIN));

   // Next-state, address and counter sequencing.
   always_comb begin
      state_next     = state_reg;
      block_next     = block_reg;
      issue_cnt_next = issue_cnt_reg;
      word_cnt_next  = word_cnt_reg;
      addr_next      = addr_reg;
      if (capture) begin
         word_cnt_next = word_cnt_reg + 2'd1;
      end
      case (state_reg)
         IDLE: begin
            if (I_start) begin
               state_next     = ISSUE;
               block_next     = 1'b0;
               issue_cnt_next = 2'd0;
               word_cnt_next  = 2'd0;
               addr_next      = 3'd0;
            end
         end
         ISSUE: begin
            if (issue_cnt_reg == LAST_WORD) begin
               // Address stays on the last word issued until the next block.
               state_next = DRAIN;
            end else begin
               issue_cnt_next = issue_cnt_reg + 2'd1;
               addr_next      = addr_reg + 3'd1;
            end
         end
         DRAIN: begin
            if (capture && (word_cnt_reg == LAST_WORD)) begin
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (I_matrix_ready) begin
               if (block_reg == LAST_BLOCK) begin
                  state_next = DONE;
               end else begin
                  state_next     = ISSUE;
                  block_next     = block_reg + 1'b1;
                  issue_cnt_next = 2'd0;
                  word_cnt_next  = 2'd0;
                  addr_next      = {block_reg + 1'b1, 2'b00};
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         state_reg     <= IDLE;
         block_reg     <= 1'b0;
         issue_cnt_reg <= 2'd0;
         word_cnt_reg  <= 2'd0;
         addr_reg      <= 3'd0;
      end else begin
         state_reg     <= state_next;
         block_reg     <= block_next;
         issue_cnt_reg <= issue_cnt_next;
         word_cnt_reg  <= word_cnt_next;
         addr_reg      <= addr_next;
      end
   end

   // Word k lands in byte lane (3-k), so the first word ends up in [31:24];
   // for a 2-bit counter, 3-k is simply the bitwise inverse of k.
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         mat_a_reg <= 32'd0;
         mat_b_reg <= 32'd0;
      end else if (capture) begin
         mat_a_reg[{~word_cnt_reg, 3'b000} +: 8] <= I_data_from_channelA;
         mat_b_reg[{~word_cnt_reg, 3'b000} +: 8] <= I_data_from_channelB;
      end
   end

   assign O_rom_ena      = (state_reg == ISSUE);
   assign O_addr         = addr_reg;
   assign O_matrix_A     = mat_a_reg;
   assign O_matrix_B     = mat_b_reg;
   assign O_matrix_valid = (state_reg == PRESENT);
   assign O_busy         = (state_reg != IDLE);
   assign O_done         = (state_reg == DONE);

endmodule

// File: tb/tb_two_channel_data_fetch.sv
// Bench for two_channel_data_fetch: a two-block instance and a one-block
// instance, each fed by a one-cycle-latency ROM model, checked against
// matrices built directly from the ROM contents.
module tb_two_channel_data_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, ready, start2, ready2;
   logic        inj_valid;
   logic [7:0]  inj_a, inj_b;
   logic [7:0]  rom_a [8];
   logic [7:0]  rom_b [8];

   // two-block instance
   logic        ena, mv, busy, done;
   logic [2:0]  addr;
   logic [31:0] mat_a, mat_b;
   logic        rv1 = 1'b0;
   logic [7:0]  rd1a = 8'd0, rd1b = 8'd0;
   logic        valid1;
   logic [7:0]  din_a, din_b;

   // one-block instance
   logic        ena2, mv2, busy2, done2;
   logic [2:0]  addr2;
   logic [31:0] mat_a2, mat_b2;
   logic        rv2 = 1'b0;
   logic [7:0]  rd2a = 8'd0, rd2b = 8'd0;

   int tests = 0;
   int fails = 0;
   int ena_cnt = 0, done_cnt = 0, mv2_cnt = 0, done2_cnt = 0;
   logic [2:0] addr_q[$];
   logic [2:0] addr2_q[$];

   assign valid1 = rv1 | inj_valid;
   assign din_a  = inj_valid ? inj_a : rd1a;
   assign din_b  = inj_valid ? inj_b : rd1b;

   two_channel_data_fetch #(.NUM_BLOCKS(2), .BLOCK_WORDS(4)) dut (
      .I_sys_clk(clk), .I_sys_rstn(rst_n), .I_start(start), .I_matrix_ready(ready),
      .I_data_from_channelA(din_a), .I_data_from_channelB(din_b),
      .I_two_channel_data_valid(valid1),
      .O_rom_ena(ena), .O_addr(addr), .O_matrix_A(mat_a), .O_matrix_B(mat_b),
      .O_matrix_valid(mv), .O_busy(busy), .O_done(done)
   );

   two_channel_data_fetch #(.NUM_BLOCKS(1), .BLOCK_WORDS(4)) dut1 (
      .I_sys_clk(clk), .I_sys_rstn(rst_n), .I_start(start2), .I_matrix_ready(ready2),
      .I_data_from_channelA(rd2a), .I_data_from_channelB(rd2b),
      .I_two_channel_data_valid(rv2),
      .O_rom_ena(ena2), .O_addr(addr2), .O_matrix_A(mat_a2), .O_matrix_B(mat_b2),
      .O_matrix_valid(mv2), .O_busy(busy2), .O_done(done2)
   );

   // ROM models: data and valid one cycle after the enable
   always @(posedge clk) begin
      rv1 <= ena;
      if (ena) begin
         rd1a <= rom_a[addr];
         rd1b <= rom_b[addr];
      end
      rv2 <= ena2;
      if (ena2) begin
         rd2a <= rom_a[addr2];
         rd2b <= rom_b[addr2];
      end
   end

   // monitors sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n && ena) begin
         addr_q.push_back(addr);
         ena_cnt++;
      end
      if (rst_n && ena2) addr2_q.push_back(addr2);
      if (mv2) mv2_cnt++;
      if (done) done_cnt++;
      if (done2) done2_cnt++;
   end

   // reference: matrix = the four ROM bytes of the block, first in the MSBs
   function automatic logic [31:0] exp_mat(input bit chb, input int blk);
      logic [31:0] m;
      m = 32'd0;
      for (int k = 0; k < 4; k++)
         m = {m[23:0], (chb ? rom_b[4*blk+k] : rom_a[4*blk+k])};
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mv(output int cyc);
      cyc = 0;
      while (!mv && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
   endtask

   task automatic load_rom_fixed();
      for (int i = 0; i < 8; i++) begin
         rom_a[i] = 8'(8'h10 + i);
         rom_b[i] = 8'(8'hA0 + i);
      end
   endtask

   task automatic load_rom_random();
      for (int i = 0; i < 8; i++) begin
         rom_a[i] = 8'($urandom);
         rom_b[i] = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({ena, addr, mat_a, mat_b, mv, busy, done} !== 70'd0) begin
         fails++;
         $display("FAIL reset_outputs: got ena=%b addr=%0d A=%h B=%h mv=%b busy=%b done=%b, want all zero",
                  ena, addr, mat_a, mat_b, mv, busy, done);
      end
      tests++;
      if ({ena2, addr2, mat_a2, mat_b2, mv2, busy2, done2} !== 70'd0) begin
         fails++;
         $display("FAIL reset_outputs_1blk: got nonzero outputs, want all zero");
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      $display("[TB] reset checked");
   endtask

   task automatic test_basic();
      int c;
      load_rom_fixed();
      addr_q.delete();
      ena_cnt = 0;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mv(c);
      tests++;
      if (!mv || (c + 1) != 6) begin
         fails++;
         $display("FAIL latency: got %0d cycles (valid=%b), want 6", c + 1, mv);
      end
      tests++;
      if (mat_a !== 32'h10111213 || mat_b !== 32'hA0A1A2A3) begin
         fails++;
         $display("FAIL basic_blk0: got A=%h B=%h, want 10111213 A0A1A2A3", mat_a, mat_b);
      end
      tick();
      tests++;
      if (mv !== 1'b0 || busy !== 1'b1 || ena !== 1'b1 || addr !== 3'd4) begin
         fails++;
         $display("FAIL basic_handshake: got mv=%b busy=%b ena=%b addr=%0d, want 0 1 1 4", mv, busy, ena, addr);
      end
      wait_mv(c);
      tests++;
      if (!mv || mat_a !== 32'h14151617 || mat_b !== 32'hA4A5A6A7) begin
         fails++;
         $display("FAIL basic_blk1: got mv=%b A=%h B=%h, want 1 14151617 A4A5A6A7", mv, mat_a, mat_b);
      end
      tick();
      tests++;
      if (done !== 1'b1 || mv !== 1'b0) begin
         fails++;
         $display("FAIL basic_done: got done=%b mv=%b, want 1 0", done, mv);
      end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", done, busy);
      end
      tests++;
      if (addr_q.size() != 8 || ena_cnt != 8) begin
         fails++;
         $display("FAIL basic_addr_count: got %0d addrs, want 8", addr_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests++;
            if (addr_q[i] !== 3'(i)) begin
               fails++;
               $display("FAIL basic_addr_seq: got addr[%0d]=%0d, want %0d", i, addr_q[i], i);
            end
         end
      end
      ready = 1'b0;
      $display("[TB] basic two-block fetch checked");
   endtask

   task automatic test_ready_stall();
      int c;
      load_rom_random();
      addr_q.delete();
      ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mv(c);
      for (int i = 0; i < 10; i++) begin
         tests++;
         if (mv !== 1'b1 || ena !== 1'b0 || mat_a !== exp_mat(0, 0) || mat_b !== exp_mat(1, 0)) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got mv=%b ena=%b A=%h B=%h, want 1 0 %h %h",
                     i, mv, ena, mat_a, mat_b, exp_mat(0, 0), exp_mat(1, 0));
         end
         tick();
      end
      tests++;
      if (addr_q.size() != 4) begin
         fails++;
         $display("FAIL stall_no_issue: got %0d addrs issued before handshake, want 4", addr_q.size());
      end
      ready = 1'b1;
      tick();
      tests++;
      if (ena !== 1'b1 || addr !== 3'd4) begin
         fails++;
         $display("FAIL stall_resume: got ena=%b addr=%0d, want 1 4", ena, addr);
      end
      wait_mv(c);
      tests++;
      if (!mv || mat_a !== exp_mat(0, 1) || mat_b !== exp_mat(1, 1)) begin
         fails++;
         $display("FAIL stall_blk1: got A=%h B=%h, want %h %h", mat_a, mat_b, exp_mat(0, 1), exp_mat(1, 1));
      end
      tick();
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL stall_done: got done=%b, want 1", done);
      end
      ready = 1'b0;
      tick();
      $display("[TB] ready stall checked");
   endtask

   task automatic test_random();
      int c;
      for (int it = 0; it < 6; it++) begin
         load_rom_random();
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int blk = 0; blk < 2; blk++) begin
            wait_mv(c);
            tests++;
            if (!mv || mat_a !== exp_mat(0, blk) || mat_b !== exp_mat(1, blk)) begin
               fails++;
               $display("FAIL random[%0d] blk%0d: got mv=%b A=%h B=%h, want %h %h",
                        it, blk, mv, mat_a, mat_b, exp_mat(0, blk), exp_mat(1, blk));
            end
            repeat ($urandom_range(0, 3)) tick();
            ready = 1'b1;
            tick();
            ready = 1'b0;
         end
         tests++;
         if (done !== 1'b1) begin
            fails++;
            $display("FAIL random[%0d] done: got %b, want 1", it, done);
         end
         tick();
         $display("[TB] random sequence %0d checked", it);
      end
   endtask

   task automatic test_start_ignored();
      int c;
      load_rom_random();
      ena_cnt = 0;
      done_cnt = 0;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(c);
      repeat (10) tick();
      tests++;
      if (ena_cnt != 8 || done_cnt != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL start_ignored: got ena_cycles=%0d dones=%0d busy=%b, want 8 1 0", ena_cnt, done_cnt, busy);
      end
      tests++;
      if (mat_a !== exp_mat(0, 1) || mat_b !== exp_mat(1, 1)) begin
         fails++;
         $display("FAIL start_ignored_data: got A=%h B=%h, want %h %h", mat_a, mat_b, exp_mat(0, 1), exp_mat(1, 1));
      end
      ready = 1'b0;
      $display("[TB] restart during issue checked");
   endtask

   task automatic test_reset_mid();
      int c;
      load_rom_fixed();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      tests++;
      if (busy !== 1'b1 || ena !== 1'b0 || mv !== 1'b0 || addr !== 3'd3) begin
         fails++;
         $display("FAIL drain_state: got busy=%b ena=%b mv=%b addr=%0d, want 1 0 0 3", busy, ena, mv, addr);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({ena, addr, mat_a, mat_b, mv, busy, done} !== 70'd0) begin
         fails++;
         $display("FAIL async_reset: got ena=%b addr=%0d A=%h B=%h mv=%b busy=%b done=%b, want all zero",
                  ena, addr, mat_a, mat_b, mv, busy, done);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      inj_valid = 1'b1;
      inj_a = 8'hFF;
      inj_b = 8'hFF;
      tick();
      inj_valid = 1'b0;
      tests++;
      if (mat_a !== 32'd0 || mat_b !== 32'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_valid: got A=%h B=%h busy=%b, want 0 0 0", mat_a, mat_b, busy);
      end
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_mv(c);
      tests++;
      if (!mv || mat_a !== 32'h10111213 || mat_b !== 32'hA0A1A2A3) begin
         fails++;
         $display("FAIL restart_after_reset: got A=%h B=%h, want 10111213 A0A1A2A3", mat_a, mat_b);
      end
      wait_done(c);
      ready = 1'b0;
      tick();
      tick();
      $display("[TB] reset during drain checked");
   endtask

   task automatic test_spurious();
      inj_valid = 1'b1;
      inj_a = 8'hFF;
      inj_b = 8'hFF;
      repeat (3) tick();
      inj_valid = 1'b0;
      tests++;
      if (mat_a !== exp_mat(0, 1) || mat_b !== exp_mat(1, 1) || busy !== 1'b0) begin
         fails++;
         $display("FAIL spurious_idle: got A=%h B=%h busy=%b, want %h %h 0",
                  mat_a, mat_b, busy, exp_mat(0, 1), exp_mat(1, 1));
      end
      $display("[TB] spurious idle valid checked");
   endtask

   task automatic test_single_block();
      int c;
      load_rom_random();
      addr2_q.delete();
      mv2_cnt = 0;
      done2_cnt = 0;
      ready2 = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      c = 0;
      while (!done2 && c < 40) begin
         if (mv2) begin
            tests++;
            if (mat_a2 !== exp_mat(0, 0) || mat_b2 !== exp_mat(1, 0)) begin
               fails++;
               $display("FAIL single_data: got A=%h B=%h, want %h %h", mat_a2, mat_b2, exp_mat(0, 0), exp_mat(1, 0));
            end
         end
         tick();
         c++;
      end
      repeat (5) tick();
      tests++;
      if (mv2_cnt != 1 || done2_cnt != 1 || addr2_q.size() != 4) begin
         fails++;
         $display("FAIL single_counts: got valids=%0d dones=%0d addrs=%0d, want 1 1 4", mv2_cnt, done2_cnt, addr2_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (addr2_q[i] !== 3'(i)) begin
               fails++;
               $display("FAIL single_addr: got addr[%0d]=%0d, want %0d", i, addr2_q[i], i);
            end
         end
      end
      ready2 = 1'b0;
      $display("[TB] single-block instance checked");
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      start2 = 1'b0;
      ready2 = 1'b0;
      inj_valid = 1'b0;
      inj_a = 8'd0;
      inj_b = 8'd0;
      for (int i = 0; i < 8; i++) begin
         rom_a[i] = 8'd0;
         rom_b[i] = 8'd0;
      end
      test_reset();
      test_basic();
      test_ready_stall();
      test_random();
      test_start_ignored();
      test_reset_mid();
      test_spurious();
      test_single_block();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
